// File: rtl/pool_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pool_window_feeder
// Description : Converts a raster-order pixel stream into 2x2 pooling
//               windows. Even rows are parked in a one-row line buffer.
//               On odd rows, each even-column pixel is held in a register.
//               The following odd-column pixel then completes a window made
//               of {linebuf[col-1], linebuf[col], held pixel, current pixel}.
// Ports       : clk           rising-edge clock
//               rst           synchronous active-high reset
//               in_valid_i    pixel on in_data_i is valid
//               in_ready_o    pixel is accepted this cycle
//               in_data_i     pixel, raster order, top row first
//               out_valid_o   window outputs are valid
//               out_ready_i   consumer accepts the window
//               num_a_o..d_o  window top-left, top-right, bottom-left,
//                             bottom-right
//               out_last_o    window is the final one of the map
// Revision    : 1.0 - initial release
// ============================================================================
module pool_window_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int MAP_WIDTH  = 28,
  parameter int MAP_HEIGHT = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] num_a_o,
  output logic [DATA_WIDTH-1:0] num_b_o,
  output logic [DATA_WIDTH-1:0] num_c_o,
  output logic [DATA_WIDTH-1:0] num_d_o,
  output logic                  out_last_o
);

  localparam int C_COL_W = (MAP_WIDTH  > 2) ? $clog2(MAP_WIDTH)  : 1;
  localparam int C_ROW_W = (MAP_HEIGHT > 2) ? $clog2(MAP_HEIGHT) : 1;
  localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(MAP_WIDTH - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(MAP_HEIGHT - 1);

  // TOP = an even row is being written; BOT = an odd row is being paired.
  localparam logic [0:0] S_TOP = 1'b0;
  localparam logic [0:0] S_BOT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [C_COL_W-1:0]    col_q, col_d;
  logic [C_ROW_W-1:0]    row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] linebuf_q [MAP_WIDTH];
  logic [DATA_WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic                  valid_q, last_q;

  logic                  w_accept;
  logic                  w_lb_we;
  logic                  w_hold_we;
  logic                  w_win_done;
  logic                  w_col_end;
  logic                  w_map_end;
  logic [C_COL_W-1:0]    w_col_prev;

  // The slot frees up when it is empty or is being drained this cycle.
  assign in_ready_o = (!valid_q || out_ready_i) && !rst;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_col_end  = (col_q == C_COL_LAST);
  assign w_map_end  = (row_q == C_ROW_LAST) && w_col_end;
  assign w_col_prev = col_q - C_COL_W'(1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_TOP;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (w_accept && w_col_end) begin
      state_d = (state_q == S_TOP) ? S_BOT : S_TOP;
    end
  end

  // ---------------- FSM: output decode ----------------
  always_comb begin
    w_lb_we    = 1'b0;
    w_hold_we  = 1'b0;
    w_win_done = 1'b0;
    if (w_accept) begin
      if (state_q == S_TOP) begin
        w_lb_we = 1'b1;
      end else if (!col_q[0]) begin
        w_hold_we = 1'b1;
      end else begin
        w_win_done = 1'b1;
      end
    end
  end

  // ---------------- Raster position counters ----------------
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (w_accept) begin
      if (w_col_end) begin
        col_d = '0;
        row_d = (row_q == C_ROW_LAST) ? '0 : row_q + C_ROW_W'(1);
      end else begin
        col_d = col_q + C_COL_W'(1);
      end
    end
  end

  // The line buffer is always fully rewritten by the TOP row before it is
  // read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_lb_we) begin
      linebuf_q[col_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (w_hold_we) begin
        hold_q <= in_data_i;
      end
      // A completing window can only be accepted when the slot is free,
      // so loading takes priority over the drain-and-clear path.
      if (w_win_done) begin
        a_q     <= linebuf_q[w_col_prev];
        b_q     <= linebuf_q[col_q];
        c_q     <= hold_q;
        d_q     <= in_data_i;
        valid_q <= 1'b1;
        last_q  <= w_map_end;
      end else if (valid_q && out_ready_i) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign num_a_o     = a_q;
  assign num_b_o     = b_q;
  assign num_c_o     = c_q;
  assign num_d_o     = d_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool_window_feeder
// Description : Self-checking bench for pool_window_feeder on a 4x4 map.
//               It compares every window against a queue-based model that
//               builds windows from the stored pixels of the current map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_window_feeder;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
    logic        last;
  } win_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] num_a, num_b, num_c, num_d;
  logic        out_last;
  win_t        cur_win;

  int   n_assert = 0;
  int   n_fail   = 0;
  win_t expq  [$];
  win_t log_q [$];
  logic [15:0] pix [0:W*H-1];
  int   p = 0;

  always #5 clk = ~clk;

  pool_window_feeder #(
    .DATA_WIDTH(16),
    .MAP_WIDTH (W),
    .MAP_HEIGHT(H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .num_a_o    (num_a),
    .num_b_o    (num_b),
    .num_c_o    (num_c),
    .num_d_o    (num_d),
    .out_last_o (out_last)
  );

  assign cur_win = {num_a, num_b, num_c, num_d, out_last};

  function automatic win_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input logic l);
    return '{a: a, b: b, c: c, d: d, last: l};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: remember the pixels of the current map by raster
  // index; each pixel at an odd row and odd column closes a 2x2 window.
  function automatic void model_push(input logic [15:0] d);
    int rr, cc;
    pix[p] = d;
    rr = p / W;
    cc = p % W;
    if ((rr % 2 == 1) && (cc % 2 == 1)) begin
      expq.push_back(mk(pix[p-W-1], pix[p-W], pix[p-1], d, p == W*H-1));
    end
    p = (p + 1) % (W*H);
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance.
  task automatic cycle(input logic v, input logic [15:0] d, input logic ordy,
                       output logic acc);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, (!out_valid || out_ready));
    chk("out_valid", out_valid, expq.size() != 0);
    if (out_valid && expq.size() != 0) chk("window", cur_win, expq[0]);
    if (out_valid && out_ready) begin
      log_q.push_back(cur_win);
      if (expq.size() != 0) void'(expq.pop_front());
    end
    acc = in_valid && in_ready;
    if (acc) model_push(d);
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d, input logic ordy);
    logic acc;
    int   k;
    acc = 1'b0;
    for (k = 0; k < 50 && !acc; k++) cycle(1'b1, d, ordy, acc);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 10 && (expq.size() != 0 || out_valid); k++)
      cycle(1'b0, 16'h0, 1'b1, acc);
    chk("drain_empty", expq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          lb;
    int          nacc;
    int          ncyc;
    int          nlast;
    logic        acc;
    logic [15:0] m1 [0:15];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // ---- Reset state ----
    in_valid = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_window", cur_win, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    // ---- Two rows of FP16 values, then filler rows ----
    m1 = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
           16'h4500, 16'h4600, 16'h4700, 16'h4800,
           16'h5000, 16'h5001, 16'h5002, 16'h5003,
           16'h5004, 16'h5005, 16'h5006, 16'h5007};
    lb = log_q.size();
    for (int i = 0; i < 16; i++) send(m1[i], 1'b1);
    drain();
    chk("t1_count", log_q.size() - lb, 4);
    if (log_q.size() - lb >= 2) begin
      chk("t1_win1", log_q[lb],   mk(16'h3C00, 16'h4000, 16'h4500, 16'h4600, 1'b0));
      chk("t1_win2", log_q[lb+1], mk(16'h4200, 16'h4400, 16'h4700, 16'h4800, 1'b0));
    end

    // ---- Map 1..16 with a 5-cycle stall on window 1 ----
    lb = log_q.size();
    for (int i = 1; i <= 6; i++) send(16'(i), 1'b1);
    for (int s = 0; s < 5; s++) begin
      cycle(1'b1, 16'h7777, 1'b0, acc);
      chk("stall_accept", acc, 0);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_window", cur_win, mk(16'h1, 16'h2, 16'h5, 16'h6, 1'b0));
    end
    chk("stall_no_transfer", log_q.size() - lb, 0);
    for (int i = 7; i <= 16; i++) send(16'(i), 1'b1);
    drain();
    chk("t2_count", log_q.size() - lb, 4);
    if (log_q.size() - lb == 4) begin
      chk("t2_win1", log_q[lb],   mk(16'h1, 16'h2, 16'h5, 16'h6, 1'b0));
      chk("t2_win2", log_q[lb+1], mk(16'h3, 16'h4, 16'h7, 16'h8, 1'b0));
      chk("t2_win3", log_q[lb+2], mk(16'h9, 16'hA, 16'hD, 16'hE, 1'b0));
      chk("t2_win4", log_q[lb+3], mk(16'hB, 16'hC, 16'hF, 16'h10, 1'b1));
    end

    // ---- Two maps back-to-back, in_valid held high ----
    lb = log_q.size();
    nacc = 0;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, 16'($urandom), 1'b1, acc);
      if (acc) nacc++;
    end
    chk("b2b_accepts", nacc, 32);
    drain();
    chk("b2b_count", log_q.size() - lb, 8);
    if (log_q.size() - lb == 8) begin
      for (int k = 0; k < 8; k++)
        chk("b2b_last", log_q[lb+k].last, (k == 3 || k == 7));
    end

    // ---- Reset after 6 pixels, then a fresh map ----
    lb = log_q.size();
    for (int i = 0; i < 6; i++) send(16'h6000 + 16'(i), 1'b1);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    expq.delete();
    p = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_window", cur_win, 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) send(16'($urandom), 1'b1);
    drain();
    chk("midrst_count", log_q.size() - lb, 4);
    if (log_q.size() - lb == 4) chk("midrst_last", log_q[lb+3].last, 1);

    // ---- Random handshake over 10 maps ----
    lb = log_q.size();
    nacc = 0;
    ncyc = 0;
    while (nacc < 160 && ncyc < 3000) begin
      cycle(($urandom_range(0, 3) != 0), 16'($urandom),
            ($urandom_range(0, 2) != 0), acc);
      if (acc) nacc++;
      ncyc++;
    end
    chk("rand_accepts", nacc, 160);
    drain();
    chk("rand_count", log_q.size() - lb, 40);
    nlast = 0;
    for (int k = lb; k < log_q.size(); k++) if (log_q[k].last) nlast++;
    chk("rand_lasts", nlast, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
